// File: rtl/booth_pp_accumulator_pkg.sv
// Shared constants, stage payload types and helpers for the Booth partial-product accumulator.
package booth_pkg;

    localparam int PP_W           = 32;
    localparam int PP_N           = 8;
    localparam int BOOTH_PIPE_LAT = 3;

    // S1 keeps four redundant vectors plus the negate-correction count.
    typedef struct packed {
        logic [3:0][PP_W-1:0] vec;
        logic [3:0]           corr;
    } s1_data_t;

    typedef struct packed {
        logic [PP_W-1:0] sum;
        logic [PP_W-1:0] carry;
    } s2_data_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Partial-product input handshake and product output handshake bundle.
interface booth_pp_accumulator_if;
    import booth_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [PP_W-1:0] pp0;
    logic [PP_W-1:0] pp1;
    logic [PP_W-1:0] pp2;
    logic [PP_W-1:0] pp3;
    logic [PP_W-1:0] pp4;
    logic [PP_W-1:0] pp5;
    logic [PP_W-1:0] pp6;
    logic [PP_W-1:0] pp7;
    logic [PP_N-1:0] cout;
    logic            out_valid;
    logic            out_ready;
    logic [PP_W-1:0] product;

    modport master (
        output in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, cout, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, cout, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/booth_pp_accumulator_csa_3to2.sv
// One row of full adders: three words in, sum word and left-shifted carry word out.
module csa_3to2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum = a ^ b ^ c;
    // The carry out of the top bit falls off: all arithmetic is modulo 2^W.
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/booth_pp_accumulator.sv
// Three-stage carry-save reduction of eight Booth partial products plus the negate
// corrections into a single product, with elastic valid/ready flow control.
module booth_pp_accumulator #(
    parameter int PP_W = booth_pkg::PP_W,
    parameter int PP_N = booth_pkg::PP_N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_pp_accumulator_if.slave bus
);
    import booth_pkg::s1_data_t;
    import booth_pkg::s2_data_t;
    import booth_pkg::popcount8;

    if (PP_N != 8) begin : g_bad_pp_n
        $error("booth_pp_accumulator supports exactly 8 partial products");
    end
    if (PP_W != booth_pkg::PP_W) begin : g_bad_pp_w
        $error("booth_pp_accumulator width must match the interface width");
    end
    if (booth_pkg::BOOTH_PIPE_LAT != 3) begin : g_bad_lat
        $error("booth_pp_accumulator is built as a three-stage pipe");
    end

    logic     s1_v, s2_v, s3_v;
    logic     s1_load, s2_load, s3_load;
    s1_data_t s1_d, s1_q;
    s2_data_t s2_d, s2_q;
    logic [PP_W-1:0] product_q;

    logic [PP_W-1:0] a_s, a_c, b_s, b_c, c_s, c_c, d_s, d_c;
    logic [PP_W-1:0] e_s, e_c, f_s, f_c, g_s, g_c;
    logic [PP_W-1:0] corr_ext;

    // Each stage may advance when it is empty or its successor is advancing.
    assign s3_load = ~s3_v | bus.out_ready;
    assign s2_load = ~s2_v | s3_load;
    assign s1_load = ~s1_v | s2_load;

    assign bus.in_ready  = rst_n & s1_load;
    assign bus.out_valid = s3_v;
    assign bus.product   = product_q;

    csa_3to2 #(.W(PP_W)) u_csa_a (.a(bus.pp0), .b(bus.pp1), .c(bus.pp2), .sum(a_s), .carry(a_c));
    csa_3to2 #(.W(PP_W)) u_csa_b (.a(bus.pp3), .b(bus.pp4), .c(bus.pp5), .sum(b_s), .carry(b_c));
    csa_3to2 #(.W(PP_W)) u_csa_c (.a(a_s),     .b(a_c),     .c(b_s),     .sum(c_s), .carry(c_c));
    csa_3to2 #(.W(PP_W)) u_csa_d (.a(b_c),     .b(bus.pp6), .c(bus.pp7), .sum(d_s), .carry(d_c));

    always_comb begin
        s1_d        = '0;
        s1_d.vec[0] = c_s;
        s1_d.vec[1] = c_c;
        s1_d.vec[2] = d_s;
        s1_d.vec[3] = d_c;
        s1_d.corr   = popcount8(bus.cout);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_load) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // The correction count is at most 8, so it enters the tree as a small third operand.
    assign corr_ext = {{(PP_W-4){1'b0}}, s1_q.corr};

    csa_3to2 #(.W(PP_W)) u_csa_e (.a(s1_q.vec[0]), .b(s1_q.vec[1]), .c(s1_q.vec[2]), .sum(e_s), .carry(e_c));
    csa_3to2 #(.W(PP_W)) u_csa_f (.a(e_s),         .b(e_c),         .c(s1_q.vec[3]), .sum(f_s), .carry(f_c));
    csa_3to2 #(.W(PP_W)) u_csa_g (.a(f_s),         .b(f_c),         .c(corr_ext),    .sum(g_s), .carry(g_c));

    always_comb begin
        s2_d       = '0;
        s2_d.sum   = g_s;
        s2_d.carry = g_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_q <= s2_d;
            end
        end
    end

    // Final carry-propagate add; the register feeds the product port directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v      <= 1'b0;
            product_q <= '0;
        end else if (s3_load) begin
            s3_v <= s2_v;
            if (s2_v) begin
                product_q <= s2_q.sum + s2_q.carry;
            end
        end
    end

endmodule
